beat_sequencer: RTL and testbench

Generates the W1/W2/W3 beat signals that step the hardwired controller (`cpu`) through each machine cycle, replacing the free-running beat stimulus with a synthesizable sequencer clocked by `t3`. It honours the controller's `short`/`long` cycle-length requests and `stop` halt request, and supports a start button (`qd`) plus a single-step mode. It also keeps a count of completed machine cycles for the front-panel display.

---
 rtl/beat_sequencer.sv | 126 ++++++++++++
 tb/tb_beat_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - W1/W2/W3 machine-cycle beat sequencer for the hardwired controller
//
// Steps the controller through each machine cycle with one-hot beats clocked
// by t3, honouring the controller's short/long cycle-length requests and its
// stop request. Runs start from a qd rising edge. step_mode halts after every
// cycle. A wrapping counter tracks completed machine cycles.
//
// Ports:
//   t3         beat clock, rising edge
//   clr        asynchronous active-low reset
//   qd         start button (debounced, asynchronous to t3)
//   step_mode  1 = halt after every machine cycle
//   short      current cycle ends after W1
//   long       current cycle runs through W3
//   stop       halt at the end of the current cycle
//   w1/w2/w3   one-hot beat outputs, all 0 when idle
//   running    any beat active
//   cyc_done   high during the final beat of a cycle
//   cyc_cnt    completed machine cycles, wraps
module beat_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic             cyc_done,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W1   = 2'd1;
    localparam logic [1:0] ST_W2   = 2'd2;
    localparam logic [1:0] ST_W3   = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       s1, s2, s3;
    logic       primed;
    logic       armed;
    logic       stop_lat;
    logic       start;
    logic       halt;

    // The reset value of the qd chain looks like "button released", so a qd
    // held through reset would otherwise produce a false rising edge. armed is
    // only set once a real post-reset sample of qd (s1, valid after one edge,
    // as flagged by primed) has been seen low.
    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            s1     <= qd;
            s2     <= s1;
            s3     <= s2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~s1);
        end
    end

    assign start = s2 & ~s3 & armed;

    // Final beat of the cycle: W1 with short (short beats long), W2 without
    // long, or W3.
    always_comb begin
        cyc_done = 1'b0;
        case (state)
            ST_W1:   cyc_done = short;
            ST_W2:   cyc_done = ~long;
            ST_W3:   cyc_done = 1'b1;
            default: cyc_done = 1'b0;
        endcase
    end

    assign halt = step_mode | stop | stop_lat;

    always_comb begin
        state_nx = state;
        if (cyc_done) begin
            state_nx = halt ? ST_IDLE : ST_W1;
        end else begin
            case (state)
                ST_IDLE: state_nx = start ? ST_W1 : ST_IDLE;
                ST_W1:   state_nx = ST_W2;
                ST_W2:   state_nx = ST_W3;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            state    <= ST_IDLE;
            stop_lat <= 1'b0;
            cyc_cnt  <= '0;
        end else begin
            state <= state_nx;
            // A stop seen in any beat is remembered until the cycle ends.
            if (state == ST_IDLE || cyc_done) begin
                stop_lat <= 1'b0;
            end else if (stop) begin
                stop_lat <= 1'b1;
            end
            if (cyc_done) begin
                cyc_cnt <= cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w1      = (state == ST_W1);
    assign w2      = (state == ST_W2);
    assign w3      = (state == ST_W3);
    assign running = (state != ST_IDLE);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - scoreboard bench for beat_sequencer
module tb_beat_sequencer;

    logic        t3 = 1'b0;
    logic        clr;
    logic        qd;
    logic        step_mode;
    logic        short;
    logic        long;
    logic        stop;
    logic        w1, w2, w3, running, cyc_done;
    logic [15:0] cyc_cnt;
    logic        w1_4, w2_4, w3_4, running4, cyc_done4;
    logic [3:0]  cyc_cnt4;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mcnt;
    logic [24:0] expq[$];

    always #5 t3 = ~t3;

    beat_sequencer #(.CNT_W(16)) dut (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode),
        .short(short), .long(long), .stop(stop),
        .w1(w1), .w2(w2), .w3(w3), .running(running),
        .cyc_done(cyc_done), .cyc_cnt(cyc_cnt)
    );

    beat_sequencer #(.CNT_W(4)) dut4 (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode),
        .short(short), .long(long), .stop(stop),
        .w1(w1_4), .w2(w2_4), .w3(w3_4), .running(running4),
        .cyc_done(cyc_done4), .cyc_cnt(cyc_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every negedge where a beat is active (or one was expected),
    // pop the scoreboard and compare {w1,w2,w3,cyc_done,running,cnt16,cnt4}.
    always @(negedge t3) begin
        logic [24:0] e;
        if (running || running4 || expq.size() != 0) begin
            e = (expq.size() != 0) ? expq.pop_front() : 25'd0;
            chk("beat", {7'd0, w1, w2, w3, cyc_done, running, cyc_cnt, cyc_cnt4}, {7'd0, e});
        end
    end

    // All calls happen at posedge+1; each consumes exactly one t3 edge.
    task automatic idle(input logic q);
        qd    = q;
        short = 1'b0;
        long  = 1'b0;
        stop  = 1'b0;
        chk("idle", {7'd0, w1, w2, w3, cyc_done, running, cyc_cnt, cyc_cnt4},
            {7'd0, 5'b00000, mcnt, mcnt[3:0]});
        @(posedge t3);
        #1;
    endtask

    task automatic beat(input logic [2:0] w, input logic d, input logic sh,
                        input logic lg, input logic sp);
        short = sh;
        long  = lg;
        stop  = sp;
        expq.push_back({w, d, 1'b1, mcnt, mcnt[3:0]});
        if (d) mcnt = mcnt + 16'd1;
        @(posedge t3);
        #1;
    endtask

    // qd low for one edge, then rising: W1 follows the third edge with qd high.
    task automatic start_run();
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        clr       = 1'b0;
        short     = 1'b0;
        long      = 1'b0;
        stop      = 1'b0;
        step_mode = 1'b0;
        #2;
        chk("reset", {7'd0, w1, w2, w3, cyc_done, running, cyc_cnt, cyc_cnt4}, 32'd0);
        @(posedge t3);
        #1;
        clr  = 1'b1;
        mcnt = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; qd = 1'b0; step_mode = 1'b0;
        short = 1'b0; long = 1'b0; stop = 1'b0; mcnt = 16'd0;
        @(posedge t3);
        #1;

        // 1: five normal cycles back to back, halted by stop in the last W2
        do_reset();
        idle(1'b0);
        start_run();
        for (int i = 0; i < 5; i++) begin
            beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
            beat(3'b010, 1'b1, 1'b0, 1'b0, (i == 4));
        end
        idle(1'b0);
        chk("cnt_after_5", {16'd0, cyc_cnt}, 32'd5);

        // 2: step mode with long cycles; qd held across the halt
        do_reset();
        step_mode = 1'b1;
        idle(1'b0);
        start_run();
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("step_cnt1", {16'd0, cyc_cnt}, 32'd1);
        start_run();
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("step_cnt2", {16'd0, cyc_cnt}, 32'd2);
        step_mode = 1'b0;

        // 3: short and long together: short wins, cyc_done every edge
        do_reset();
        idle(1'b0);
        start_run();
        for (int i = 0; i < 4; i++) beat(3'b100, 1'b1, 1'b1, 1'b1, (i == 3));
        idle(1'b0);

        // 4: stop pulse in W1 of a normal cycle, then stop in W3 of a long cycle
        do_reset();
        idle(1'b0);
        start_run();
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        start_run();
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("stop_cnt", {16'd0, cyc_cnt}, 32'd2);

        // 5: clr during W2 at count 7, qd held high through reset
        do_reset();
        idle(1'b0);
        start_run();
        for (int i = 0; i < 7; i++) begin
            beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
            beat(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_clr", {15'd0, w2, cyc_cnt}, {15'd0, 1'b1, 16'd7});
        clr = 1'b0;
        #2;
        chk("async_clr", {7'd0, w1, w2, w3, cyc_done, running, cyc_cnt, cyc_cnt4}, 32'd0);
        @(posedge t3);
        #1;
        clr  = 1'b1;
        mcnt = 16'd0;
        for (int i = 0; i < 4; i++) idle(1'b1);
        start_run();
        beat(3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        chk("restart_cnt", {16'd0, cyc_cnt}, 32'd1);

        // 6: 17 short cycles: the 4-bit counter wraps 15 -> 0 -> 1
        do_reset();
        idle(1'b0);
        start_run();
        for (int i = 0; i < 17; i++) beat(3'b100, 1'b1, 1'b1, 1'b0, (i == 16));
        idle(1'b0);
        chk("wrap_cnt4", {28'd0, cyc_cnt4}, 32'd1);
        chk("wrap_cnt16", {16'd0, cyc_cnt}, 32'd17);

        chk("queue_drained", expq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
